// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential shift-and-add-3 (double-dabble) binary-to-BCD
// converter feeding the per-digit BCD-to-7-segment decoders.
//
// One input bit is consumed per clock. A conversion accepted on edge E
// presents its result with a one-cycle done pulse after edge E+WIDTH. bcd and
// blank are updated only on that done edge, so the displays hold steady
// between conversions.
//
// Optional feature macro: BIN2BCD_LZB_EN
//   defined   : blank is a registered leading-zero mask. blank[i] (i>=1) is set
//               when digit i and every digit above it are zero. blank[0] is
//               never set, so a value of 0 still shows one "0".
//   undefined : blank is tied to zero and no blanking logic exists.
//
// Ports:
//   clk    in   1          system clock, rising edge
//   rst    in   1          asynchronous reset, active low
//   start  in   1          conversion request, accepted only when idle
//   bin    in   WIDTH      unsigned value, captured on the accepted start edge
//   busy   out  1          high while a conversion is iterating
//   done   out  1          one-cycle pulse when bcd/blank are updated
//   bcd    out  4*DIGITS   packed BCD digits, digit 0 (units) in bits [3:0]
//   blank  out  DIGITS     leading-zero blank mask

module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    logic [0:0]       state;
    logic [BW-1:0]    scratch;
    logic [WIDTH-1:0] binreg;
    logic [CW-1:0]    count;

    logic [BW-1:0]       scratch_adj;
    logic [BW+WIDTH-1:0] shifted;
    logic [BW-1:0]       scratch_nxt;
    logic [WIDTH-1:0]    binreg_nxt;

    // Correct every nibble that would reach 10 or more after doubling.
    // A nibble >= 5 is at most 9 here, so +3 never carries out of the nibble.
    function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] s);
        logic [BW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Correct-then-shift happens in one combinational step: one bit per cycle.
    always_comb begin
        scratch_adj = add3_all(scratch);
        shifted     = {scratch_adj, binreg} << 1;
        scratch_nxt = shifted[BW+WIDTH-1:WIDTH];
        binreg_nxt  = shifted[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            scratch <= '0;
            binreg  <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        binreg  <= bin;
                        scratch <= '0;
                        count   <= CW'(WIDTH);
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    scratch <= scratch_nxt;
                    binreg  <= binreg_nxt;
                    count   <= count - CW'(1);
                    // Last shift: publish the post-shift scratch directly so
                    // the result lands on the same edge as the final bit.
                    if (count == CW'(1)) begin
                        bcd   <= scratch_nxt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BIN2BCD_LZB_EN
    // Walk from the top digit down; a digit blanks only while everything
    // above it (and itself) is still zero. Digit 0 is never blanked.
    function automatic logic [DIGITS-1:0] lzb_mask(input logic [BW-1:0] d);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (d[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

    // Registered alongside bcd so both change on the same done edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank <= '0;
        end else if (state == CONV && count == CW'(1)) begin
            blank <= lzb_mask(scratch_nxt);
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic                clk;
    logic                rst;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;

    int n_vec = 0;
    int n_err = 0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by plain division.
    function automatic logic [4*DIGITS-1:0] model_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Reference: digit i (i>=1) blanks when the value has fewer than i+1 digits.
    function automatic logic [DIGITS-1:0] model_blank(input int v);
        logic [DIGITS-1:0] m;
        int p;
        m = '0;
`ifdef BIN2BCD_LZB_EN
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            m[i] = (v < p);
            p = p * 10;
        end
`else
        p = 0;
        if (v < p) m = '1;
`endif
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one conversion and run until done (bounded). lat = cycles from
    // the accepting edge to the done sample, -1 on timeout.
    task automatic convert(input int v, output int lat, output int busy_n,
                           output bit bcd_moved);
        logic [4*DIGITS-1:0] prev;
        prev      = bcd;
        bin       = WIDTH'(v);
        start     = 1'b1;
        step();
        start     = 1'b0;
        busy_n    = busy ? 1 : 0;
        lat       = -1;
        bcd_moved = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
            if (bcd !== prev) bcd_moved = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        bin   = '0;
        step();
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
        n_vec++; if (bcd !== '0) begin n_err++; $display("FAIL reset_bcd got=%h want=0", bcd); end
        n_vec++; if (blank !== '0) begin n_err++; $display("FAIL reset_blank got=%b want=0", blank); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_zero();
        int lat, bn;
        bit mv;
        convert(0, lat, bn, mv);
        n_vec++; if (lat !== 16) begin n_err++; $display("FAIL zero_latency got=%0d want=16", lat); end
        n_vec++; if (bcd !== model_bcd(0)) begin n_err++; $display("FAIL zero_bcd got=%h want=%h", bcd, model_bcd(0)); end
        n_vec++; if (blank !== model_blank(0)) begin n_err++; $display("FAIL zero_blank got=%b want=%b", blank, model_blank(0)); end
    endtask

    task automatic test_max();
        int lat, bn;
        bit mv;
        convert(65535, lat, bn, mv);
        n_vec++; if (lat !== 16) begin n_err++; $display("FAIL max_latency got=%0d want=16", lat); end
        n_vec++; if (bn !== 16) begin n_err++; $display("FAIL max_busy_cycles got=%0d want=16", bn); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL max_busy_at_done got=%b want=0", busy); end
        n_vec++; if (bcd !== 20'h65535) begin n_err++; $display("FAIL max_bcd got=%h want=65535", bcd); end
        n_vec++; if (blank !== model_blank(65535)) begin n_err++; $display("FAIL max_blank got=%b want=%b", blank, model_blank(65535)); end
        step();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL max_done_width got=%b want=0", done); end
        n_vec++; if (bcd !== 20'h65535) begin n_err++; $display("FAIL max_bcd_hold got=%h want=65535", bcd); end
    endtask

    task automatic test_1234();
        int lat, bn;
        bit mv;
        convert(1234, lat, bn, mv);
        n_vec++; if (mv !== 1'b0) begin n_err++; $display("FAIL 1234_bcd_during_conv got=%b want=0", mv); end
        n_vec++; if (bcd !== 20'h01234) begin n_err++; $display("FAIL 1234_bcd got=%h want=01234", bcd); end
        n_vec++; if (blank !== model_blank(1234)) begin n_err++; $display("FAIL 1234_blank got=%b want=%b", blank, model_blank(1234)); end
    endtask

    task automatic test_ignore_busy();
        int dones;
        logic [4*DIGITS-1:0] seen;
        dones = 0;
        seen  = '0;
        bin   = WIDTH'(99);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5) begin
                bin   = WIDTH'(7);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            if (done) begin
                dones++;
                seen = bcd;
            end
        end
        start = 1'b0;
        n_vec++; if (dones !== 1) begin n_err++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
        n_vec++; if (seen !== 20'h00099) begin n_err++; $display("FAIL ignore_bcd got=%h want=00099", seen); end
    endtask

    task automatic test_reset_mid();
        int dones, lat, bn;
        bit mv;
        dones = 0;
        bin   = WIDTH'(500);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n < 8; n++) step();
        rst = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b want=0", busy); end
        n_vec++; if (bcd !== '0) begin n_err++; $display("FAIL midrst_bcd got=%h want=0", bcd); end
        n_vec++; if (blank !== '0) begin n_err++; $display("FAIL midrst_blank got=%b want=0", blank); end
        step();
        step();
        rst = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (done) dones++;
        end
        n_vec++; if (dones !== 0) begin n_err++; $display("FAIL midrst_aborted_done got=%0d want=0", dones); end
        convert(42, lat, bn, mv);
        n_vec++; if (lat !== 16) begin n_err++; $display("FAIL midrst_latency got=%0d want=16", lat); end
        n_vec++; if (bcd !== 20'h00042) begin n_err++; $display("FAIL midrst_bcd42 got=%h want=00042", bcd); end
    endtask

    task automatic test_back_to_back();
        int gap, first;
        bit held_ok;
        first = -1;
        gap   = -1;
        held_ok = 1'b1;
        bin   = WIDTH'(12345);
        start = 1'b1;
        step();
        for (int n = 1; n <= 40; n++) begin
            step();
            if (done) begin first = n; break; end
        end
        n_vec++; if (first !== 16) begin n_err++; $display("FAIL b2b_first_latency got=%0d want=16", first); end
        n_vec++; if (bcd !== 20'h12345) begin n_err++; $display("FAIL b2b_first_bcd got=%h want=12345", bcd); end
        bin = WIDTH'(54321);
        for (int n = 1; n <= 40; n++) begin
            step();
            if (done) begin gap = n; break; end
            if (bcd !== 20'h12345) held_ok = 1'b0;
        end
        start = 1'b0;
        n_vec++; if (gap !== 17) begin n_err++; $display("FAIL b2b_done_gap got=%0d want=17", gap); end
        n_vec++; if (held_ok !== 1'b1) begin n_err++; $display("FAIL b2b_hold got=%b want=1", held_ok); end
        n_vec++; if (bcd !== 20'h54321) begin n_err++; $display("FAIL b2b_second_bcd got=%h want=54321", bcd); end
        step();
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_after got=%b want=0", busy); end
    endtask

    task automatic test_random();
        int v, lat, bn;
        bit mv;
        for (int k = 0; k < 16; k++) begin
            v = int'($urandom_range(0, 65535));
            if (k == 0) v = 9;
            if (k == 1) v = 10;
            convert(v, lat, bn, mv);
            n_vec++; if (lat !== 16) begin n_err++; $display("FAIL rand_latency v=%0d got=%0d want=16", v, lat); end
            n_vec++; if (bcd !== model_bcd(v)) begin n_err++; $display("FAIL rand_bcd v=%0d got=%h want=%h", v, bcd, model_bcd(v)); end
            n_vec++; if (blank !== model_blank(v)) begin n_err++; $display("FAIL rand_blank v=%0d got=%b want=%b", v, blank, model_blank(v)); end
            if ((k % 3) == 0) step();
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        bin   = '0;
        test_reset();
        test_zero();
        test_max();
        test_1234();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
- Sits directly upstream of the per-digit BCD-to-7-segment decoders. Takes the multiplier's binary product and produces one 4-bit BCD digit per display.
- Uses a start/done handshake. Results are held stable between conversions so the displays never flicker.

Parameters:
- WIDTH, 16, bit width of the binary input (the multiplier product).
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- start  input  1  request conversion of bin; sampled on the rising edge of clk
- bin  input  WIDTH  unsigned binary value; captured on the accepted start edge only
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd is updated
- bcd  output  4*DIGITS  packed BCD digits; digit i in bits [4i+3:4i]; digit 0 is the units digit
- blank  output  DIGITS  leading-zero blank mask, one bit per digit (see Optional Feature)

Behaviour:
- Clock and reset: single clock domain, clk only. rst is asynchronous and active-low.
- Reset values (rst=0): state=IDLE, busy=0, done=0, bcd=0, blank=0, internal shift and count registers=0.
- States:
  - IDLE: waiting for start.
  - CONV: iterating.
- IDLE -> CONV when start=1 at an edge:
  - bin is loaded into the binary shift register.
  - The BCD scratch register is cleared.
  - count is set to WIDTH.
  - busy=1 from the next cycle.
- CONV, each edge:
  - Every scratch nibble >= 5 gets +3.
  - Then {scratch, binreg} shifts left by 1.
  - count decrements.
  - Add and shift are combinational within one cycle, so there is one bit per cycle.
- CONV -> IDLE on the edge where count reaches 0 (the WIDTH-th shift edge):
  - The final scratch value is registered into bcd.
  - done=1 for exactly one cycle.
  - busy=0.
- Latency: start accepted at edge E; bcd valid and done=1 in the cycle after edge E+WIDTH. With WIDTH=16, that is 16 cycles after the start edge.
- start while busy=1 is ignored. No queueing; bin is not re-sampled.
- start asserted in the same cycle done=1 is accepted (back-to-back). The new conversion begins and the previous bcd stays held until the next done.
- bcd and blank change only on the done edge, never during CONV.
- start held high continuously: one conversion begins per return to IDLE, i.e. every WIDTH+1 cycles.
- Reset mid-conversion:
  - Immediate return to IDLE with all outputs at their reset values.
  - No done pulse is produced for the aborted conversion.
- Arithmetic:
  - Nibble add-3 is 4-bit with no carry out. A nibble is never > 9 after correction.
  - Maximum input 2^WIDTH-1 converts exactly with no overflow, given the DIGITS constraint.
- Any unused upper digits (value 0) remain 0.

Optional Feature:
- Macro: BIN2BCD_LZB_EN.
- Defined:
  - On each done edge, blank[i]=1 iff digit i and every digit above it are 0, for i>=1.
  - blank[0] is always 0, so value 0 shows a single "0".
  - blank is registered together with bcd.
- Undefined:
  - blank is tied to all zeros; no blanking logic is synthesised.
  - Downstream displays show all leading zeros.

Test Plan:
- Reset, then start with bin=0 -> done pulses 16 cycles after the start edge; bcd=0x00000; blank=5'b11110 with LZB_EN, 5'b00000 without.
- bin=65535 -> bcd=0x65535; blank=0; busy high for exactly 16 cycles; done high for exactly 1 cycle.
- bin=1234 -> bcd=0x01234; blank=5'b10000 with LZB_EN.
- bin=99, then start pulsed 5 cycles later with bin=7 -> second start ignored; result 0x00099; one done only.
- Start bin=500; assert rst at cycle 8; release; start bin=42 -> no done for 500; outputs 0 during reset; then bcd=0x00042 after 16 cycles.
- Back-to-back: start held high with bin=12345, then bin=54321 on the done cycle -> bcd=0x12345 held for 17 cycles, then 0x54321; done pulses exactly 17 cycles apart.
